// File: rtl/bus_term_fifo_bank.sv
// Bank of per-terminal TX/RX show-ahead FIFO pairs between the stimulus/monitor
// side and the bus generator/arbiter ports, with overflow policy, occupancy
// reporting and saturating per-terminal drop counters.

// Single show-ahead FIFO. The head is forced to zero while the FIFO is empty.
// When the FIFO is full and a write arrives without a read, OVF_MODE selects
// between discarding the new word (0) and overwriting the oldest entry (1).
module bus_term_fifo #(
    parameter int W        = 16,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic          avail,
    output logic [W-1:0]  head,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          avail_q;
    logic          full_q;
    logic          do_rd;
    logic          do_wr;
    logic          rd_adv;
    logic          overflow;
    logic          overwrite;

    // Decide which of the requested operations take effect this cycle.
    always_comb begin
        do_rd     = rd && avail_q;
        overflow  = wr && full_q && !rd;
        overwrite = overflow && (OVF_MODE != 0);
        do_wr     = wr && (!overflow || overwrite);
        rd_adv    = do_rd || overwrite;
        cnt_next  = cnt_q;
        if (do_wr && !rd_adv) begin
            cnt_next = cnt_q + CW'(1);
        end else if (rd_adv && !do_wr) begin
            cnt_next = cnt_q - CW'(1);
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            avail_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q   <= cnt_next;
            avail_q <= (cnt_next != '0);
            full_q  <= (cnt_next == CW'(DEPTH));
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign avail = avail_q;
    assign head  = avail_q ? mem[rd_ptr] : '0;
    assign cnt   = cnt_q;
    assign ovf   = overflow;

endmodule

// Top level: DRVRS independent terminals, each with a TX FIFO feeding the bus,
// an RX FIFO capturing bus deliveries and an 8-bit saturating overflow counter.
module bus_term_fifo_bank #(
    parameter int DRVRS    = 4,
    parameter int PCKG_SZ  = 16,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DRVRS-1:0]            tx_wr,
    input  logic [DRVRS*PCKG_SZ-1:0]    tx_wdata,
    output logic [DRVRS-1:0]            tx_full,
    output logic [DRVRS-1:0]            pndng,
    input  logic [DRVRS-1:0]            pop,
    output logic [DRVRS*PCKG_SZ-1:0]    D_pop,
    input  logic [DRVRS-1:0]            push,
    input  logic [DRVRS*PCKG_SZ-1:0]    D_push,
    output logic [DRVRS-1:0]            rx_valid,
    output logic [DRVRS*PCKG_SZ-1:0]    rx_rdata,
    input  logic [DRVRS-1:0]            rx_rd,
    output logic [DRVRS*(AW+1)-1:0]     tx_cnt,
    output logic [DRVRS*(AW+1)-1:0]     rx_cnt,
    output logic [DRVRS*8-1:0]          drop_cnt
);

    for (genvar i = 0; i < DRVRS; i++) begin : g_term
        logic       tx_ovf;
        logic       rx_ovf;
        logic [7:0] drop_q;
        logic [8:0] drop_sum;

        bus_term_fifo #(
            .W        (PCKG_SZ),
            .DEPTH    (DEPTH),
            .OVF_MODE (OVF_MODE)
        ) u_tx (
            .clk   (clk),
            .reset (reset),
            .wr    (tx_wr[i]),
            .wdata (tx_wdata[i*PCKG_SZ +: PCKG_SZ]),
            .rd    (pop[i]),
            .avail (pndng[i]),
            .head  (D_pop[i*PCKG_SZ +: PCKG_SZ]),
            .cnt   (tx_cnt[i*(AW+1) +: AW+1]),
            .ovf   (tx_ovf)
        );

        bus_term_fifo #(
            .W        (PCKG_SZ),
            .DEPTH    (DEPTH),
            .OVF_MODE (OVF_MODE)
        ) u_rx (
            .clk   (clk),
            .reset (reset),
            .wr    (push[i]),
            .wdata (D_push[i*PCKG_SZ +: PCKG_SZ]),
            .rd    (rx_rd[i]),
            .avail (rx_valid[i]),
            .head  (rx_rdata[i*PCKG_SZ +: PCKG_SZ]),
            .cnt   (rx_cnt[i*(AW+1) +: AW+1]),
            .ovf   (rx_ovf)
        );

        // Full flag derived from the registered occupancy only.
        assign tx_full[i] = (tx_cnt[i*(AW+1) +: AW+1] == (AW+1)'(DEPTH));

        // TX and RX overflows in one cycle add two; the sum is one bit wider to catch saturation.
        always_comb begin
            drop_sum = {1'b0, drop_q} + {8'd0, tx_ovf} + {8'd0, rx_ovf};
        end

        // Saturating per-terminal overflow counter.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                drop_q <= '0;
            end else begin
                drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end

        assign drop_cnt[i*8 +: 8] = drop_q;
    end

endmodule
